// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the MIPS multi-cycle controller.
// BEQ support is enabled by defining MIPS_CTRL_BEQ_EN.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {
    CLS_ILL  = 3'd0,
    CLS_ADD  = 3'd1,
    CLS_SUB  = 3'd2,
    CLS_ADDI = 3'd3,
    CLS_LW   = 3'd4,
    CLS_SW   = 3'd5,
    CLS_BEQ  = 3'd6
  } instr_cls_t;

  // Second ALU operand is the sign-extended immediate for these classes.
  function automatic logic uses_imm(input instr_cls_t c);
    return (c == CLS_ADDI) || (c == CLS_LW) || (c == CLS_SW);
  endfunction

  function automatic logic [3:0] alu_op(input instr_cls_t c);
    return ((c == CLS_SUB) || (c == CLS_BEQ)) ? ALU_SUB : ALU_ADD;
  endfunction

endpackage

// File: rtl/mips_main_decoder.sv
// Combinational instruction classifier: opcode/funct to class and legality.
// Honours MIPS_CTRL_BEQ_EN (BEQ legal only when defined).
module mips_main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output instr_cls_t  cls,
  output logic        legal
);

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADD) begin
          cls = CLS_ADD;
        end else if (funct == FN_SUB) begin
          cls = CLS_SUB;
        end
      end
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
`ifdef MIPS_CTRL_BEQ_EN
      OP_BEQ:  cls = CLS_BEQ;
`else
      OP_BEQ:  cls = CLS_ILL;
`endif
      default: cls = CLS_ILL;
    endcase
    legal = (cls != CLS_ILL);
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: owns IR, sequences FETCH/DECODE/EXEC/MEM/WB.
// Optional BEQ support via MIPS_CTRL_BEQ_EN; default build treats BEQ as illegal.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  output logic [31:0]      ir,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             alu_src,
  output logic [3:0]       alu_ctrl,
  output logic             mem_we,
  output logic             mem_to_reg,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       ir_we_q, ir_we_d;
  logic       pc_we_q, pc_we_d;
  logic       pc_src_en_q, pc_src_en_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_dst_q, reg_dst_d;
  logic       alu_src_q, alu_src_d;
  logic [3:0] alu_ctrl_q, alu_ctrl_d;
  logic       mem_we_q, mem_we_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic       busy_q, busy_d;
  logic       illegal_q, illegal_d;

  instr_cls_t cls;
  logic       legal;
  state_t     after_done;

  mips_main_decoder u_dec (
    .opcode (ir_q[31:26]),
    .funct  (ir_q[5:0]),
    .cls    (cls),
    .legal  (legal)
  );

  assign after_done = run ? S_FETCH : S_IDLE;

  // Next state, IR and retirement counter.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, pc_we_q};
    if (pc_we_q) begin
      state_d = after_done;
    end else begin
      case (state_q)
        S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
        S_FETCH: begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
        S_DECODE: state_d = legal ? S_EXEC : S_ERR;
        S_EXEC:   state_d = ((cls == CLS_LW) || (cls == CLS_SW)) ? S_MEM : S_WB;
        S_MEM:    state_d = S_WB;
        S_WB:     state_d = S_IDLE;
        S_ERR:    state_d = S_ERR;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered: decoded from the state being entered and the held IR,
  // so during each cycle they reflect the current state only.
  always_comb begin
    ir_we_d      = 1'b0;
    pc_we_d      = 1'b0;
    pc_src_en_d  = 1'b0;
    reg_we_d     = 1'b0;
    reg_dst_d    = 1'b0;
    alu_src_d    = 1'b0;
    alu_ctrl_d   = 4'b0000;
    mem_we_d     = 1'b0;
    mem_to_reg_d = 1'b0;
    busy_d       = 1'b0;
    illegal_d    = 1'b0;
    case (state_d)
      S_FETCH: begin
        ir_we_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_DECODE: busy_d = 1'b1;
      S_EXEC: begin
        busy_d     = 1'b1;
        alu_src_d  = uses_imm(cls);
        alu_ctrl_d = alu_op(cls);
        if (cls == CLS_BEQ) begin
          pc_we_d     = 1'b1;
          pc_src_en_d = 1'b1;
        end
      end
      S_MEM: begin
        busy_d     = 1'b1;
        alu_src_d  = uses_imm(cls);
        alu_ctrl_d = alu_op(cls);
        if (cls == CLS_SW) begin
          mem_we_d = 1'b1;
          pc_we_d  = 1'b1;
        end
      end
      S_WB: begin
        busy_d       = 1'b1;
        alu_src_d    = uses_imm(cls);
        alu_ctrl_d   = alu_op(cls);
        reg_we_d     = 1'b1;
        pc_we_d      = 1'b1;
        reg_dst_d    = (cls == CLS_ADD) || (cls == CLS_SUB);
        mem_to_reg_d = (cls == CLS_LW);
      end
      S_ERR:   illegal_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ir_q         <= '0;
      retired_q    <= '0;
      ir_we_q      <= 1'b0;
      pc_we_q      <= 1'b0;
      pc_src_en_q  <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= 4'b0000;
      mem_we_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
      busy_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      retired_q    <= retired_d;
      ir_we_q      <= ir_we_d;
      pc_we_q      <= pc_we_d;
      pc_src_en_q  <= pc_src_en_d;
      reg_we_q     <= reg_we_d;
      reg_dst_q    <= reg_dst_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      mem_we_q     <= mem_we_d;
      mem_to_reg_q <= mem_to_reg_d;
      busy_q       <= busy_d;
      illegal_q    <= illegal_d;
    end
  end

`ifdef MIPS_CTRL_BEQ_EN
  // The branch decision is only known while the ALU compares in EXEC, so the
  // registered enable is gated by the live Zero flag.
  assign pc_src = pc_src_en_q & alu_zero;
`else
  logic unused_beq;
  assign unused_beq = alu_zero | pc_src_en_q;
  assign pc_src = 1'b0;
`endif

  assign ir         = ir_q;
  assign ir_we      = ir_we_q;
  assign pc_we      = pc_we_q;
  assign reg_we     = reg_we_q;
  assign reg_dst    = reg_dst_q;
  assign alu_src    = alu_src_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign mem_we     = mem_we_q;
  assign mem_to_reg = mem_to_reg_q;
  assign busy       = busy_q;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against a per-instruction schedule model.
// Honours MIPS_CTRL_BEQ_EN to choose BEQ legality expectations.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset, run, alu_zero;
  logic [31:0] instr;

  logic [31:0] ir, retired;
  logic        ir_we, pc_we, pc_src, reg_we, reg_dst, alu_src, mem_we, mem_to_reg, busy, illegal;
  logic [3:0]  alu_ctrl;

  logic [31:0] b_ir;
  logic [1:0]  b_retired;
  logic        b_ir_we, b_pc_we, b_pc_src, b_reg_we, b_reg_dst, b_alu_src, b_mem_we, b_mem_to_reg;
  logic        b_busy, b_illegal;
  logic [3:0]  b_alu_ctrl;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .alu_zero(alu_zero),
    .ir(ir), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .reg_dst(reg_dst), .alu_src(alu_src), .alu_ctrl(alu_ctrl), .mem_we(mem_we),
    .mem_to_reg(mem_to_reg), .busy(busy), .illegal(illegal), .retired(retired)
  );

  // Narrow-counter instance shares all stimulus; only its wrap behaviour is checked.
  mips_multicycle_ctrl #(.CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .alu_zero(alu_zero),
    .ir(b_ir), .ir_we(b_ir_we), .pc_we(b_pc_we), .pc_src(b_pc_src), .reg_we(b_reg_we),
    .reg_dst(b_reg_dst), .alu_src(b_alu_src), .alu_ctrl(b_alu_ctrl), .mem_we(b_mem_we),
    .mem_to_reg(b_mem_to_reg), .busy(b_busy), .illegal(b_illegal), .retired(b_retired)
  );

  always #5 clk = ~clk;

`ifdef MIPS_CTRL_BEQ_EN
  localparam bit BEQ_EN = 1'b1;
`else
  localparam bit BEQ_EN = 1'b0;
`endif
  localparam int ERR_CYCLES = 10;

  typedef struct packed {
    logic        ir_we, pc_we, pc_src, reg_we, reg_dst, alu_src;
    logic [3:0]  alu_ctrl;
    logic        mem_we, mem_to_reg, busy, illegal;
    logic [31:0] ir;
    logic [31:0] retired;
    logic        sel_care, alu_care;
  } vec_t;

  vec_t        eq[$];
  logic [31:0] iq[$];
  logic [31:0] m_ir, m_ret;
  int          tests = 0, fails = 0, cyc = 0;
  bit          run_low = 1'b0;
  int          zero_mode = 0;

  function automatic vec_t observe(input vec_t e);
    vec_t o;
    o = '0;
    o.ir_we = ir_we; o.pc_we = pc_we; o.pc_src = pc_src; o.reg_we = reg_we;
    o.reg_dst = reg_dst; o.alu_src = alu_src; o.alu_ctrl = alu_ctrl; o.mem_we = mem_we;
    o.mem_to_reg = mem_to_reg; o.busy = busy; o.illegal = illegal;
    o.ir = ir; o.retired = retired;
    o.sel_care = e.sel_care; o.alu_care = e.alu_care;
    if (!e.sel_care) begin o.reg_dst = e.reg_dst; o.mem_to_reg = e.mem_to_reg; end
    if (!e.alu_care) begin o.alu_src = e.alu_src; o.alu_ctrl = e.alu_ctrl; end
    return o;
  endfunction

  function automatic logic [31:0] rand_legal();
    int k;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    k = BEQ_EN ? $urandom_range(0, 5) : $urandom_range(0, 4);
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
    case (k)
      0:       return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1:       return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      2:       return {6'h08, rs, rt, imm};
      3:       return {6'h23, rs, rt, imm};
      4:       return {6'h2B, rs, rt, imm};
      default: return {6'h04, rs, rt, imm};
    endcase
  endfunction

  task automatic push_idle();
    vec_t v = '0;
    eq.push_back(v);
  endtask

  // Expected per-cycle schedule of one instruction, from the instruction's class.
  task automatic push_instr(input logic [31:0] ins);
    vec_t v;
    logic [5:0] op, fn;
    bit is_add, is_sub, is_addi, is_lw, is_sw, is_beq;
    op = ins[31:26]; fn = ins[5:0];
    is_add  = (op == 6'h00) && (fn == 6'h20);
    is_sub  = (op == 6'h00) && (fn == 6'h22);
    is_addi = (op == 6'h08);
    is_lw   = (op == 6'h23);
    is_sw   = (op == 6'h2B);
    is_beq  = (op == 6'h04) && BEQ_EN;
    iq.push_back(ins);
    v = '0; v.ir_we = 1'b1; v.busy = 1'b1; eq.push_back(v);
    v = '0; v.busy = 1'b1; eq.push_back(v);
    if (!(is_add || is_sub || is_addi || is_lw || is_sw || is_beq)) begin
      for (int i = 0; i < ERR_CYCLES; i++) begin
        v = '0; v.illegal = 1'b1; eq.push_back(v);
      end
      return;
    end
    v = '0; v.busy = 1'b1; v.alu_care = 1'b1;
    v.alu_src  = is_addi || is_lw || is_sw;
    v.alu_ctrl = (is_sub || is_beq) ? 4'b0110 : 4'b0010;
    if (is_beq) begin v.pc_we = 1'b1; v.pc_src = 1'b1; end
    eq.push_back(v);
    if (is_beq) return;
    v.pc_we = 1'b0; v.pc_src = 1'b0;
    if (is_lw || is_sw) begin
      if (is_sw) begin v.mem_we = 1'b1; v.pc_we = 1'b1; end
      eq.push_back(v);
      if (is_sw) return;
    end
    v.mem_we = 1'b0; v.reg_we = 1'b1; v.pc_we = 1'b1; v.sel_care = 1'b1;
    v.reg_dst = is_add || is_sub;
    v.mem_to_reg = is_lw;
    eq.push_back(v);
  endtask

  // Advance one cycle: returns observed/expected for the current cycle, then drives inputs.
  task automatic step(output vec_t o, output vec_t e);
    e = eq.pop_front();
    e.ir = m_ir;
    e.retired = m_ret;
    e.pc_src = e.pc_src & alu_zero;
    o = observe(e);
    if (e.ir_we) begin
      instr = iq.pop_front();
      m_ir = instr;
    end else begin
      instr = $urandom;
    end
    if (e.pc_we) m_ret = m_ret + 1;
    if (e.illegal) run = 1'b1;
    else if (e.pc_we || !e.busy) run = (iq.size() != 0);
    else run = run_low ? 1'b0 : 1'($urandom_range(0, 1));
    alu_zero = (zero_mode == 0) ? 1'($urandom_range(0, 1)) : (zero_mode == 1);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ir = '0; m_ret = '0;
    eq.delete(); iq.delete();
  endtask

  task automatic test_reset();
    vec_t o, z;
    z = '0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run = 1'($urandom_range(0, 1)); instr = $urandom;
      @(posedge clk); #1;
      o = observe(z);
      tests++;
      if (o !== z) begin fails++; $display("FAIL reset_hold got=%h want=%h", o, z); end
    end
    reset = 1'b0; run = 1'b0; m_ir = '0; m_ret = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      o = observe(z);
      tests++;
      if (o !== z) begin fails++; $display("FAIL reset_idle got=%h want=%h", o, z); end
    end
  endtask

  task automatic test_addi();
    vec_t o, e;
    do_reset();
    push_idle(); push_instr(32'h20080005); push_idle();
    while (eq.size() > 0) begin
      step(o, e);
      tests++;
      if (o !== e) begin fails++; $display("FAIL addi cyc=%0d got=%h want=%h", cyc, o, e); end
    end
    tests++;
    if (retired !== 32'd1) begin fails++; $display("FAIL addi_retired got=%0d want=1", retired); end
  endtask

  task automatic test_back_to_back();
    vec_t o, e;
    int pcyc[$];
    do_reset();
    push_idle();
    push_instr({6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20});
    push_instr({6'h00, 5'd10, 5'd8, 5'd11, 5'd0, 6'h22});
    push_idle();
    while (eq.size() > 0) begin
      if (eq[0].pc_we) pcyc.push_back(cyc);
      step(o, e);
      tests++;
      if (o !== e) begin fails++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, o, e); end
    end
    tests++;
    if (pcyc.size() != 2 || (pcyc[1] - pcyc[0]) != 4) begin
      fails++; $display("FAIL b2b_spacing got=%0d want=4", (pcyc.size() == 2) ? pcyc[1] - pcyc[0] : -1);
    end
    tests++;
    if (retired !== 32'd2) begin fails++; $display("FAIL b2b_retired got=%0d want=2", retired); end
  endtask

  task automatic test_mem();
    vec_t o, e;
    do_reset();
    push_idle(); push_instr(32'hAC080000); push_instr(32'h8C0C0000); push_idle();
    while (eq.size() > 0) begin
      step(o, e);
      tests++;
      if (o !== e) begin fails++; $display("FAIL mem cyc=%0d got=%h want=%h", cyc, o, e); end
    end
  endtask

  task automatic test_illegal();
    vec_t o, e, z;
    logic [31:0] bad[3];
    bad[0] = {6'h3F, 26'($urandom)};
    bad[1] = {6'h00, 20'($urandom), 6'h2A};
    bad[2] = {6'h04, 26'($urandom)};
    for (int k = 0; k < (BEQ_EN ? 2 : 3); k++) begin
      do_reset();
      push_idle(); push_instr(bad[k]);
      while (eq.size() > 0) begin
        step(o, e);
        tests++;
        if (o !== e) begin fails++; $display("FAIL illegal%0d cyc=%0d got=%h want=%h", k, cyc, o, e); end
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; run = 1'b0; m_ir = '0; m_ret = '0;
      z = '0;
      o = observe(z);
      tests++;
      if (o !== z) begin fails++; $display("FAIL illegal_clear%0d got=%h want=%h", k, o, z); end
    end
  endtask

  task automatic test_run_drop();
    vec_t o, e;
    do_reset();
    run_low = 1'b1;
    push_idle(); push_instr({6'h08, 10'($urandom), 16'($urandom)}); push_idle(); push_idle();
    while (eq.size() > 0) begin
      step(o, e);
      tests++;
      if (o !== e) begin fails++; $display("FAIL run_drop cyc=%0d got=%h want=%h", cyc, o, e); end
    end
    run_low = 1'b0;
  endtask

  task automatic test_abort_lw();
    vec_t o, e, z;
    do_reset();
    push_idle(); push_instr({6'h23, 10'($urandom), 16'($urandom)});
    void'(eq.pop_back());
    while (eq.size() > 0) begin
      if (eq.size() == 1) reset = 1'b1;
      step(o, e);
      tests++;
      if (o !== e) begin fails++; $display("FAIL abort_lw cyc=%0d got=%h want=%h", cyc, o, e); end
    end
    reset = 1'b0; run = 1'b0; m_ir = '0; m_ret = '0;
    z = '0;
    for (int i = 0; i < 2; i++) begin
      o = observe(z);
      tests++;
      if (o !== z) begin fails++; $display("FAIL abort_idle%0d got=%h want=%h", i, o, z); end
      @(posedge clk); #1;
    end
  endtask

`ifdef MIPS_CTRL_BEQ_EN
  task automatic test_beq();
    vec_t o, e;
    for (int z = 1; z <= 2; z++) begin
      do_reset();
      zero_mode = z;
      alu_zero = (z == 1);
      push_idle(); push_instr({6'h04, 10'($urandom), 16'($urandom)}); push_idle();
      while (eq.size() > 0) begin
        step(o, e);
        tests++;
        if (o !== e) begin fails++; $display("FAIL beq_z%0d cyc=%0d got=%h want=%h", z, cyc, o, e); end
      end
    end
    zero_mode = 0;
  endtask
`endif

  task automatic test_random(input int n, input bit wrap_check);
    vec_t o, e;
    do_reset();
    push_idle();
    for (int i = 0; i < n; i++) push_instr(rand_legal());
    push_idle();
    while (eq.size() > 0) begin
      step(o, e);
      tests++;
      if (o !== e) begin fails++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, o, e); end
    end
    tests++;
    if (retired !== 32'(n)) begin fails++; $display("FAIL random_retired got=%0d want=%0d", retired, n); end
    tests++;
    if (b_retired !== 2'(n % 4)) begin fails++; $display("FAIL wrap_retired got=%0d want=%0d", b_retired, n % 4); end
    if (wrap_check) begin
      tests++;
      if (b_retired !== 2'd1) begin fails++; $display("FAIL wrap5 got=%0d want=1", b_retired); end
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; instr = '0; alu_zero = 1'b0;
    m_ir = '0; m_ret = '0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_mem();
    test_illegal();
    test_run_drop();
    test_abort_lw();
`ifdef MIPS_CTRL_BEQ_EN
    test_beq();
`endif
    test_random(5, 1'b1);
    test_random(60, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the MIPS datapath: instruction memory, `regsFile` (A1/A2/A3/WE3/WD3) and `alu` (ALUSrc/aluCtrl/Zero). It owns the instruction register and steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, so one ALU and one register-file write port are shared across cycles. Supports ADDI, ADD, SUB, LW and SW; BEQ is optional.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high; sampled on rising edge of clk.
run  in  1  level; permits starting a new instruction.
instr  in  32  instruction-memory RD at current PC (combinational).
alu_zero  in  1  ALU Zero flag; used only by BEQ.
ir  out  32  instruction register; feeds rs/rt/rd/imm decode.
ir_we  out  1  IR load strobe (FETCH).
pc_we  out  1  PC update strobe; exactly one cycle per retired instruction.
pc_src  out  1  0 = PC+4, 1 = branch target (PC+4+(SignImm<<2)).
reg_we  out  1  regsFile WE3.
reg_dst  out  1  A3 select: 0 = rt, 1 = rd.
alu_src  out  1  0 = RD2, 1 = SignImm.
alu_ctrl  out  4  ADD = 4'b0010, SUB = 4'b0110.
mem_we  out  1  data-memory write enable.
mem_to_reg  out  1  WD3 select: 0 = ALUResult, 1 = memory read data.
busy  out  1  1 in any state other than IDLE or ERR.
illegal  out  1  sticky; 1 while in ERR.
retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (synchronous, active-high): state = IDLE, ir = 0, retired = 0, illegal = 0. All strobes and selects are 0. Reset wins over every other event. Reset mid-instruction aborts it with no write issued on the reset cycle or afterwards.
- Outputs are Moore: decoded from the state register and ir only. No combinational path from any input to any output.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR.
- IDLE: go to FETCH when run = 1.
- FETCH: ir_we = 1; ir <= instr; go to DECODE.
- DECODE: classify ir. Any unsupported opcode or funct goes to ERR. Opcode 0 is supported only with funct 100000 (ADD) or 100010 (SUB).
- EXEC: drive alu_ctrl and alu_src.
  - ADDI, LW, SW: ADD with alu_src = 1.
  - ADD: alu_ctrl = 0010, alu_src = 0. SUB: alu_ctrl = 0110, alu_src = 0.
  - Next state: ADD/SUB/ADDI go to WB; LW/SW go to MEM.
- alu_ctrl and alu_src hold their EXEC values through MEM and WB of the same instruction.
- MEM:
  - SW: mem_we = 1 and pc_we = 1 in the same cycle (instruction ends).
  - LW: go to WB.
- WB: reg_we = 1 and pc_we = 1.
  - reg_dst = 1 for ADD/SUB, 0 for ADDI/LW.
  - mem_to_reg = 1 for LW only.
- Latency, FETCH to pc_we inclusive: ADD/SUB/ADDI = 4 cycles, LW = 5, SW = 4.
- Completion (any cycle with pc_we = 1):
  - retired increments and wraps modulo 2^CNT_W.
  - Next state is FETCH if run = 1, else IDLE. No bubble cycle between instructions.
- Dropping run mid-instruction never aborts it; the controller stops after the current pc_we.
- ERR: all strobes 0, illegal = 1, busy = 0. Stays in ERR until reset; run is ignored.
- Exactly one of reg_we or mem_we asserts per instruction, and never both in one cycle.

Optional Feature:
MIPS_CTRL_BEQ_EN
- Defined: opcode 000100 (BEQ) is legal. DECODE goes to EXEC. EXEC drives alu_ctrl = 0110, alu_src = 0, pc_we = 1, pc_src = alu_zero; the instruction retires in 3 cycles with no reg_we or mem_we.
- Undefined: BEQ is illegal and goes to ERR. pc_src is tied to 0.

Decomposition:
- mips_ctrl_pkg holds:
  - state enumeration (3-bit);
  - opcode constants: OP_RTYPE 000000, OP_ADDI 001000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100;
  - funct constants: FN_ADD 100000, FN_SUB 100010;
  - ALU codes: ALU_ADD 0010, ALU_SUB 0110;
  - instruction-class enum.
- Sub-module mips_main_decoder: purely combinational. Maps ir to {class, legal}; the FSM consumes it.

Test Plan:
1. Reset, run = 1, ADDI $8,$0,5 (0x20080005) → FETCH, DECODE, EXEC, WB. In WB: reg_we = 1, reg_dst = 0, alu_src = 1, alu_ctrl = 0010. pc_we pulses in cycle 4; retired = 1.
2. ADD $10,$8,$9 then SUB $11,$10,$8 back-to-back with run held → pc_we exactly every 4 cycles. reg_dst = 1; alu_ctrl is 0010 for ADD, then 0110 for SUB; retired = 2.
3. SW $8,0($0) (0xAC080000) then LW $12,0($0) (0x8C0C0000) → SW: mem_we = 1 and pc_we = 1 in cycle 4, reg_we never set. LW: 5 cycles, mem_to_reg = 1 and reg_we = 1 in WB.
4. Opcode 0x3F, or R-type funct 0x2A → ERR after DECODE, illegal = 1, no further strobes for 10 cycles with run = 1. Then reset → IDLE, illegal = 0.
5. Drop run in EXEC of ADDI → WB still completes, then IDLE, busy = 0. Assert reset during MEM of LW → no reg_we, state IDLE next cycle.
6. With MIPS_CTRL_BEQ_EN: BEQ, alu_zero = 1 → pc_we = 1 and pc_src = 1 in cycle 3. With alu_zero = 0 → pc_src = 0. Without the macro, BEQ → ERR. With CNT_W = 2, 5 retirements → retired = 1.
